// File: rtl/sparse_mac_row.sv
// rtl/sparse_mac_row.sv - systolic row of sparse MAC PEs with drain and result streaming
module sparse_mac_row #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_PE     = 4,
  parameter int IDX_WIDTH  = 4,
  localparam int OUT_IDX_WIDTH = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                                       Clk,
  input  logic                                       rst,
  input  logic [BLOCK_SIZE*BLOCK_SIZE*DATA_WIDTH-1:0] act_block,
  input  logic [DATA_WIDTH-1:0]                      weight_in,
  input  logic [NUM_PE*IDX_WIDTH-1:0]                idx_in,
  input  logic [NUM_PE*ACC_WIDTH-1:0]                bias_in,
  input  logic                                       is_signed,
  input  logic                                       block_last,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [ACC_WIDTH-1:0]                       out_data,
  output logic [OUT_IDX_WIDTH-1:0]                   out_idx,
  output logic                                       out_last,
  output logic                                       out_valid,
  input  logic                                       out_ready
);
  localparam int NE = BLOCK_SIZE * BLOCK_SIZE;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;
  state_t state;

  logic [NE*DATA_WIDTH-1:0]     act_q;
  logic                         signed_q;
  logic [NUM_PE-1:0]            st_valid;
  logic [DATA_WIDTH-1:0]        st_w   [NUM_PE];
  logic [NUM_PE*IDX_WIDTH-1:0]  st_idx [NUM_PE];
  logic [ACC_WIDTH-1:0]         acc    [NUM_PE];
  logic [ACC_WIDTH-1:0]         prod   [NUM_PE];
  logic [OUT_IDX_WIDTH-1:0]     drain_cnt;
  logic                         accept;

  assign in_ready = (state == IDLE) || (state == ACCUM);
  assign accept   = in_valid && in_ready;

  // Operands are widened to ACC_WIDTH first so one multiplier serves both signed and unsigned modes.
  always_comb begin
    logic [DATA_WIDTH-1:0] sel;
    logic [ACC_WIDTH-1:0]  ax;
    logic [ACC_WIDTH-1:0]  wx;
    sel = '0;
    ax  = '0;
    wx  = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      sel = act_q[DATA_WIDTH-1:0];
      for (int e = 0; e < NE; e++) begin
        if (st_idx[k][k*IDX_WIDTH +: IDX_WIDTH] == IDX_WIDTH'(e))
          sel = act_q[e*DATA_WIDTH +: DATA_WIDTH];
      end
      ax = signed_q ? {{(ACC_WIDTH-DATA_WIDTH){sel[DATA_WIDTH-1]}}, sel}
                    : {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, sel};
      wx = signed_q ? {{(ACC_WIDTH-DATA_WIDTH){st_w[k][DATA_WIDTH-1]}}, st_w[k]}
                    : {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, st_w[k]};
      prod[k] = ax * wx;
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (out_idx == OUT_IDX_WIDTH'(k))
        out_data = acc[k];
    end
  end

  assign out_last = out_valid && (out_idx == OUT_IDX_WIDTH'(NUM_PE - 1));

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      act_q     <= '0;
      signed_q  <= 1'b0;
      st_valid  <= '0;
      drain_cnt <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      for (int k = 0; k < NUM_PE; k++) begin
        st_w[k]   <= '0;
        st_idx[k] <= '0;
        acc[k]    <= '0;
      end
    end else begin
      st_valid[0] <= accept;
      st_w[0]     <= weight_in;
      st_idx[0]   <= idx_in;
      for (int k = 1; k < NUM_PE; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_w[k]     <= st_w[k-1];
        st_idx[k]   <= st_idx[k-1];
      end
      for (int k = 0; k < NUM_PE; k++) begin
        if (st_valid[k])
          acc[k] <= acc[k] + prod[k];
      end

      case (state)
        IDLE: begin
          if (accept) begin
            act_q     <= act_block;
            signed_q  <= is_signed;
            drain_cnt <= '0;
            // Pipeline is empty between blocks, so the bias load never collides with an update.
            for (int k = 0; k < NUM_PE; k++)
              acc[k] <= bias_in[k*ACC_WIDTH +: ACC_WIDTH];
            state <= block_last ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (accept && block_last) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == OUT_IDX_WIDTH'(NUM_PE - 1)) begin
            state     <= OUTPUT;
            out_valid <= 1'b1;
            out_idx   <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (out_idx == OUT_IDX_WIDTH'(NUM_PE - 1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_idx   <= '0;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sparse_mac_row.sv
// tb/tb_sparse_mac_row.sv - self-checking bench for sparse_mac_row
module tb_sparse_mac_row;
  localparam int NUM_PE = 4;

  logic         Clk = 1'b0;
  logic         rst;
  logic [127:0] act_block;
  logic [7:0]   weight_in;
  logic [15:0]  idx_in;
  logic [127:0] bias_in;
  logic         is_signed, block_last, in_valid, in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_idx;
  logic         out_last, out_valid, out_ready;

  sparse_mac_row dut (
    .Clk(Clk), .rst(rst), .act_block(act_block), .weight_in(weight_in),
    .idx_in(idx_in), .bias_in(bias_in), .is_signed(is_signed),
    .block_last(block_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [127:0] act;
    logic [7:0]   w;
    logic [15:0]  idx;
    logic [127:0] bias;
    logic         sgn;
    logic [127:0] expv;
  } vec_t;

  vec_t         tbl [6];
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  exp_res  [NUM_PE];
  logic [31:0]  model_acc[NUM_PE];
  logic [127:0] act_seq, act_80, act_1, act_5;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] mprod(input logic [127:0] act, input logic sgn,
                                        input logic [7:0] w, input logic [3:0] idx);
    logic [7:0] a;
    int ai, wi;
    a  = act[int'(idx)*8 +: 8];
    ai = sgn ? int'($signed(a)) : int'(a);
    wi = sgn ? int'($signed(w)) : int'(w);
    return 32'(ai * wi);
  endfunction

  task automatic send_elem(input logic [127:0] act, input logic [7:0] w, input logic [15:0] idx,
                           input logic [127:0] bias, input logic sgn, input logic last);
    act_block  = act;
    weight_in  = w;
    idx_in     = idx;
    bias_in    = bias;
    is_signed  = sgn;
    block_last = last;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    block_last = 1'b0;
  endtask

  task automatic wait_latency;
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(NUM_PE));
  endtask

  task automatic drain_results(input bit rnd);
    for (int i = 0; i < NUM_PE; i++) begin
      int guard = 0;
      bit done = 1'b0;
      while (!done && guard < 50) begin
        out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("out_idx", 64'(out_idx), 64'(i));
        chk("out_data", 64'(out_data), 64'(exp_res[i]));
        chk("out_last", 64'(out_last), 64'(i == NUM_PE - 1));
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        done = out_ready;
        tick();
        guard++;
      end
      chk("handshake", 64'(done), 64'd1);
    end
    out_ready = 1'b1;
    chk("out_valid_end", 64'(out_valid), 64'd0);
    chk("in_ready_end", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [127:0] ract, rbias;
    logic [7:0]   rw;
    logic [15:0]  ridx;
    logic         rsgn;
    int           len;

    rst = 1'b1; act_block = '0; weight_in = '0; idx_in = '0; bias_in = '0;
    is_signed = 1'b0; block_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int e = 0; e < 16; e++) begin
      act_seq[e*8 +: 8] = 8'(e + 1);
      act_80[e*8 +: 8]  = 8'h80;
      act_1[e*8 +: 8]   = 8'h01;
      act_5[e*8 +: 8]   = 8'h05;
    end
    tbl[0] = '{act_seq, 8'h01, 16'h3333, {32'd230, 32'd220, 32'd210, 32'd200}, 1'b0,
               {32'd234, 32'd224, 32'd214, 32'd204}};
    tbl[1] = '{act_seq, 8'hFF, 16'hFFFF, 128'd0, 1'b1, {4{32'hFFFFFFF0}}};
    tbl[2] = '{act_seq, 8'hFF, 16'hFFFF, 128'd0, 1'b0, {4{32'h00000FF0}}};
    tbl[3] = '{act_1, 8'h01, 16'h0000, {4{32'hFFFFFFFF}}, 1'b0, 128'd0};
    tbl[4] = '{act_seq, 8'h03, 16'hFA50, 128'd0, 1'b0, {32'd48, 32'd33, 32'd18, 32'd3}};
    tbl[5] = '{act_80, 8'h02, 16'h7C41, {4{32'h00000100}}, 1'b1, 128'd0};

    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      send_elem(tbl[v].act, tbl[v].w, tbl[v].idx, tbl[v].bias, tbl[v].sgn, 1'b1);
      for (int k = 0; k < NUM_PE; k++) exp_res[k] = tbl[v].expv[k*32 +: 32];
      wait_latency();
      drain_results(1'b0);
    end

    // multi-element block with a bubble; later act_block values must be ignored
    send_elem(act_seq, 8'd1, 16'h0000, {32'd230, 32'd220, 32'd210, 32'd200}, 1'b0, 1'b0);
    send_elem(act_80, 8'd2, 16'h1111, 128'd0, 1'b1, 1'b0);
    tick();
    send_elem(act_1, 8'd3, 16'h2222, 128'd0, 1'b0, 1'b1);
    exp_res = '{32'd214, 32'd224, 32'd234, 32'd244};
    wait_latency();
    drain_results(1'b0);

    // output backpressure with ignored input pulses
    send_elem(tbl[0].act, tbl[0].w, tbl[0].idx, tbl[0].bias, 1'b0, 1'b1);
    exp_res = '{32'd204, 32'd214, 32'd224, 32'd234};
    out_ready = 1'b0;
    wait_latency();
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; weight_in = 8'h7F; block_last = 1'b1; act_block = act_80;
      chk("bp_out_data", 64'(out_data), 64'd204);
      chk("bp_out_idx", 64'(out_idx), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0; block_last = 1'b0;
    drain_results(1'b0);

    // reset in the middle of a block
    send_elem(act_seq, 8'd9, 16'h1234, 128'd77, 1'b0, 1'b0);
    send_elem(act_seq, 8'd9, 16'h4321, 128'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    send_elem(act_5, 8'd2, 16'($urandom), 128'd0, 1'b0, 1'b1);
    exp_res = '{32'd10, 32'd10, 32'd10, 32'd10};
    wait_latency();
    drain_results(1'b0);

    // randomized blocks against the arithmetic model
    for (int b = 0; b < 12; b++) begin
      len   = $urandom_range(1, 5);
      rsgn  = 1'($urandom);
      ract  = {$urandom, $urandom, $urandom, $urandom};
      rbias = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < NUM_PE; k++) model_acc[k] = rbias[k*32 +: 32];
      for (int j = 0; j < len; j++) begin
        rw   = 8'($urandom);
        ridx = 16'($urandom);
        if (j > 0 && $urandom_range(0, 2) == 0) tick();
        send_elem((j == 0) ? ract : {$urandom, $urandom, $urandom, $urandom}, rw, ridx,
                  (j == 0) ? rbias : 128'd0, (j == 0) ? rsgn : ~rsgn, 1'(j == len - 1));
        for (int k = 0; k < NUM_PE; k++)
          model_acc[k] = model_acc[k] + mprod(ract, rsgn, rw, ridx[k*4 +: 4]);
      end
      exp_res = model_acc;
      wait_latency();
      drain_results(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
